// File: rtl/thread_fetch_sched.sv
// thread_fetch_sched: fine-grained multithreaded fetch front end.
// Holds one PC per hardware thread and issues round-robin over the live
// threads into a 1-cycle synchronous instruction RAM. A thread retires when
// its halt opcode comes back. Branch redirects arrive from execute.
// Optional feature macro: CYCLE_COUNT_EN adds the run_cycles output.
module thread_fetch_sched #(
  parameter int INST_WIDTH      = 32,
  parameter int INST_ADDR_WIDTH = 9,
  parameter int THREAD_BITS     = 2,
  parameter int NUM_THREADS     = 2**THREAD_BITS
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  output logic [INST_ADDR_WIDTH-1:0] imem_addr,
  input  logic [INST_WIDTH-1:0]      imem_rdata,
  output logic [INST_WIDTH-1:0]      inst_out,
  output logic [THREAD_BITS-1:0]     thread_id_out,
  output logic                       inst_valid,
  input  logic                       br_taken,
  input  logic [THREAD_BITS-1:0]     br_thread,
  input  logic [INST_ADDR_WIDTH-1:0] br_target,
  output logic [NUM_THREADS-1:0]     thread_done_out,
  output logic                       busy,
  output logic                       all_done
`ifdef CYCLE_COUNT_EN
  ,
  output logic [31:0]                run_cycles
`endif
);

  localparam int BASE_SHIFT = INST_ADDR_WIDTH - THREAD_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [INST_ADDR_WIDTH-1:0]   pc_q [NUM_THREADS];
  logic [INST_ADDR_WIDTH-1:0]   pc_d [NUM_THREADS];
  logic [NUM_THREADS-1:0]       done_q, done_d;
  logic [THREAD_BITS-1:0]       rr_q, rr_d;
  logic [THREAD_BITS-1:0]       f_tid_q, f_tid_d;
  logic                         f_valid_q, f_valid_d;
  logic                         squash_q, squash_d;
  logic [INST_ADDR_WIDTH-1:0]   addr_q, addr_d;

  logic                         running;
  logic                         restart;
  logic                         halt_ret;
  logic                         issue;
  logic [THREAD_BITS-1:0]       issue_tid;
  logic                         br_ok;
  logic [NUM_THREADS-1:0]       eligible;

  // Each thread starts in its own equal slice of instruction memory.
  function automatic logic [INST_ADDR_WIDTH-1:0] base_pc(input int t);
    return INST_ADDR_WIDTH'(t) << BASE_SHIFT;
  endfunction

  assign running         = (state_q == RUN);
  assign restart         = start && !running;
  assign inst_valid      = f_valid_q & ~(done_q[f_tid_q] | squash_q);
  assign inst_out        = inst_valid ? imem_rdata : '0;
  assign thread_id_out   = f_tid_q;
  assign halt_ret        = inst_valid && (inst_out[INST_WIDTH-1 -: 6] == 6'b111111);
  assign thread_done_out = done_q;
  assign busy            = running;
  assign all_done        = (state_q == DONE);
  assign imem_addr       = issue ? pc_q[issue_tid] : addr_q;

  // A redirect to a retired thread, or to a thread whose halt is returning now, is dropped.
  assign br_ok = running && br_taken && !done_q[br_thread]
                 && !(halt_ret && (f_tid_q == br_thread));

  // Threads that may issue this cycle; a thread whose halt is returning is already out.
  always_comb begin
    eligible = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      eligible[t] = ~done_q[t] & ~(halt_ret && (f_tid_q == THREAD_BITS'(t)));
    end
  end

  // Round-robin pick: first eligible thread after the last one issued.
  always_comb begin
    issue     = 1'b0;
    issue_tid = rr_q;
    for (int k = 1; k <= NUM_THREADS; k++) begin
      if (!issue && running && eligible[rr_q + THREAD_BITS'(k)]) begin
        issue     = 1'b1;
        issue_tid = rr_q + THREAD_BITS'(k);
      end
    end
  end

  // FSM next state: leave RUN only once every done flag is already registered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (&done_q) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Thread context update: restart reload, issue/increment, redirect, retirement.
  always_comb begin
    pc_d      = pc_q;
    done_d    = done_q;
    rr_d      = rr_q;
    f_valid_d = 1'b0;
    f_tid_d   = f_tid_q;
    squash_d  = 1'b0;
    addr_d    = addr_q;
    if (restart) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        pc_d[t] = base_pc(t);
      end
      done_d = '0;
      rr_d   = THREAD_BITS'(NUM_THREADS - 1);
    end else begin
      if (issue) begin
        pc_d[issue_tid] = pc_q[issue_tid] + INST_ADDR_WIDTH'(1);
        rr_d            = issue_tid;
        f_valid_d       = 1'b1;
        f_tid_d         = issue_tid;
        addr_d          = pc_q[issue_tid];
        // The fetch just sent down the old path of a redirected thread is dead.
        squash_d        = br_ok && (br_thread == issue_tid);
      end
      // Redirect overrides the increment of the same thread.
      if (br_ok) pc_d[br_thread] = br_target;
      if (halt_ret) done_d[f_tid_q] = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Thread contexts and fetch-stage registers; reset discards any in-flight fetch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        pc_q[t] <= base_pc(t);
      end
      done_q    <= '0;
      rr_q      <= THREAD_BITS'(NUM_THREADS - 1);
      f_valid_q <= 1'b0;
      f_tid_q   <= '0;
      squash_q  <= 1'b0;
      addr_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      done_q    <= done_d;
      rr_q      <= rr_d;
      f_valid_q <= f_valid_d;
      f_tid_q   <= f_tid_d;
      squash_q  <= squash_d;
      addr_q    <= addr_d;
    end
  end

`ifdef CYCLE_COUNT_EN
  logic [31:0] cyc_q, cyc_d;

  assign run_cycles = cyc_q;

  // Cycle counter: zeroed when a run begins, counts RUN cycles, holds otherwise.
  always_comb begin
    cyc_d = cyc_q;
    if (restart)      cyc_d = '0;
    else if (running) cyc_d = cyc_q + 32'd1;
  end

  // Cycle counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc_q <= '0;
    else          cyc_q <= cyc_d;
  end
`endif

endmodule

// File: tb/tb_thread_fetch_sched.sv
// Bench for thread_fetch_sched: vector table, directed corner sequences and
// randomized runs checked against a cycle-level behavioural model.
module tb_thread_fetch_sched;
  localparam int IW = 32;
  localparam int AW = 9;
  localparam int TB = 2;
  localparam int NT = 4;
  localparam logic [31:0] HALT = 32'hFC00_0ABC;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic [IW-1:0] inst_out;
  logic [TB-1:0] thread_id_out;
  logic          inst_valid;
  logic          br_taken = 1'b0;
  logic [TB-1:0] br_thread = '0;
  logic [AW-1:0] br_target = '0;
  logic [NT-1:0] thread_done_out;
  logic          busy;
  logic          all_done;
`ifdef CYCLE_COUNT_EN
  logic [31:0]   run_cycles;
`endif

  logic [IW-1:0] mem [0:(1<<AW)-1];

  thread_fetch_sched #(.INST_WIDTH(IW), .INST_ADDR_WIDTH(AW), .THREAD_BITS(TB), .NUM_THREADS(NT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .inst_out(inst_out), .thread_id_out(thread_id_out), .inst_valid(inst_valid),
    .br_taken(br_taken), .br_thread(br_thread), .br_target(br_target),
    .thread_done_out(thread_done_out), .busy(busy), .all_done(all_done)
`ifdef CYCLE_COUNT_EN
    , .run_cycles(run_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous instruction RAM, one cycle read latency.
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] nh(input int a);
    return 32'h0100_0000 + 32'(a);
  endfunction

  // ---------------- behavioural model ----------------
  int  m_state;           // 0 idle, 1 run, 2 done
  int  m_pc [NT];
  bit  m_done [NT];
  int  m_last;
  bit  m_flv, m_flk;
  int  m_flt, m_fla;
  int  m_hold;
  int  m_cyc;
  bit  pend;
  // per-cycle expectations
  bit          e_valid, e_halt, e_found;
  logic [31:0] e_inst;
  int          e_t, e_addr;

  function automatic logic [NT-1:0] m_done_vec();
    logic [NT-1:0] v;
    for (int t = 0; t < NT; t++) v[t] = m_done[t];
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0;
    for (int t = 0; t < NT; t++) begin m_pc[t] = t * (1 << (AW - TB)); m_done[t] = 0; end
    m_last = NT - 1; m_flv = 0; m_flk = 0; m_flt = 0; m_fla = 0; m_hold = 0; m_cyc = 0;
  endtask

  task automatic model_eval();
    e_valid = m_flv && !m_flk && !m_done[m_flt];
    e_inst  = e_valid ? mem[m_fla] : 32'h0;
    e_halt  = e_valid && (e_inst[31:26] == 6'h3F);
    e_found = 0; e_t = 0;
    if (m_state == 1) begin
      for (int k = 1; k <= NT; k++) begin
        int t;
        t = (m_last + k) % NT;
        if (!e_found && !m_done[t] && !(e_halt && t == m_flt)) begin e_found = 1; e_t = t; end
      end
    end
    e_addr = e_found ? m_pc[e_t] : m_hold;
  endtask

  task automatic model_compare();
    chk("m_imem_addr", imem_addr, e_addr);
    chk("m_inst_valid", inst_valid, e_valid);
    chk("m_inst_out", inst_out, e_inst);
    if (e_valid) chk("m_thread_id", thread_id_out, m_flt);
    chk("m_thread_done", thread_done_out, m_done_vec());
    chk("m_busy", busy, m_state == 1);
    chk("m_all_done", all_done, m_state == 2);
`ifdef CYCLE_COUNT_EN
    chk("m_run_cycles", run_cycles, m_cyc);
`endif
  endtask

  task automatic model_update();
    bit all_before, brok;
    int old_t, bt;
    if (m_state != 1) begin
      if (start) begin
        m_state = 1;
        for (int t = 0; t < NT; t++) begin m_pc[t] = t * (1 << (AW - TB)); m_done[t] = 0; end
        m_last = NT - 1; m_cyc = 0;
      end
      m_flv = 0;
    end else begin
      m_cyc++;
      all_before = (m_done_vec() == {NT{1'b1}});
      bt = int'(br_thread);
      brok = br_taken && !m_done[bt] && !(e_halt && bt == m_flt);
      old_t = m_flt;
      if (e_found) begin
        m_flv = 1; m_flt = e_t; m_fla = m_pc[e_t]; m_flk = brok && (bt == e_t);
        m_hold = m_pc[e_t]; m_pc[e_t] = (m_pc[e_t] + 1) % (1 << AW); m_last = e_t;
      end else begin
        m_flv = 0;
      end
      if (brok) m_pc[bt] = int'(br_target);
      if (e_halt) m_done[old_t] = 1;
      if (all_before) m_state = 2;
    end
  endtask

  // Apply one cycle of inputs at the falling edge and check against the model.
  task automatic drive(input logic s, input logic bt, input logic [TB-1:0] bth, input logic [AW-1:0] btg);
    if (pend) model_update();
    @(negedge clk);
    start = s; br_taken = bt; br_thread = bth; br_target = btg;
    #1;
    model_eval();
    model_compare();
    pend = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; start = 0; br_taken = 0; br_thread = 0; br_target = 0;
    #1;
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst_out", inst_out, 0);
    chk("rst_thread_id", thread_id_out, 0);
    chk("rst_thread_done", thread_done_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_all_done", all_done, 0);
`ifdef CYCLE_COUNT_EN
    chk("rst_run_cycles", run_cycles, 0);
`endif
    model_reset();
    pend = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic fill_plain();
    for (int a = 0; a < (1 << AW); a++) mem[a] = nh(a);
  endtask

  typedef struct {
    logic          start;
    logic [AW-1:0] addr;
    logic          valid;
    logic [TB-1:0] tid;
    logic [IW-1:0] inst;
    logic          busy;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{1'b0, 9'd0,   1'b0, 2'd0, 32'h0,         1'b0};
    tbl[1] = '{1'b1, 9'd0,   1'b0, 2'd0, 32'h0,         1'b0};
    tbl[2] = '{1'b0, 9'd0,   1'b0, 2'd0, 32'h0,         1'b1};
    tbl[3] = '{1'b0, 9'd128, 1'b1, 2'd0, 32'h0100_0000, 1'b1};
    tbl[4] = '{1'b0, 9'd256, 1'b1, 2'd1, 32'h0100_0080, 1'b1};
    tbl[5] = '{1'b0, 9'd384, 1'b1, 2'd2, 32'h0100_0100, 1'b1};
    tbl[6] = '{1'b0, 9'd1,   1'b1, 2'd3, 32'h0100_0180, 1'b1};
    tbl[7] = '{1'b0, 9'd129, 1'b1, 2'd0, 32'h0100_0001, 1'b1};
    pend = 0;
    model_reset();
    fill_plain();

    // Basic round-robin from reset, vector table.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].start, 1'b0, '0, '0);
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), inst_valid, tbl[i].valid);
      chk($sformatf("tbl%0d_inst", i), inst_out, tbl[i].inst);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      if (tbl[i].valid) chk($sformatf("tbl%0d_tid", i), thread_id_out, tbl[i].tid);
    end

    // Thread 2 halts at 258; remaining order is 0,1,3.
    do_reset();
    fill_plain();
    mem[258] = HALT;
    drive(1, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      drive(0, 0, 0, 0);
      if (thread_done_out == 4'b0100) break;
    end
    chk("halt2_done", thread_done_out, 4'b0100);
    for (int i = 0; i < 6; i++) begin
      logic [TB-1:0] exp_t;
      if (i > 0) drive(0, 0, 0, 0);
      exp_t = (i % 3 == 2) ? 2'd3 : TB'(i % 3);
      chk($sformatf("halt2_order%0d", i), imem_addr[AW-1 -: TB], exp_t);
    end

    // All threads halt at base+2, then restart from DONE.
    do_reset();
    fill_plain();
    mem[2] = HALT; mem[130] = HALT; mem[258] = HALT; mem[386] = HALT;
    drive(1, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      drive(0, 0, 0, 0);
      if (thread_done_out == 4'hF) break;
    end
    chk("alld_done_bits", thread_done_out, 4'hF);
    chk("alld_not_yet", all_done, 0);
    chk("alld_still_busy", busy, 1);
    drive(0, 0, 0, 0);
    chk("alld_all_done", all_done, 1);
    chk("alld_busy_low", busy, 0);
    drive(1, 0, 0, 0);
    chk("alld_pulse_cycle", all_done, 1);
    drive(0, 0, 0, 0);
    chk("restart_busy", busy, 1);
    chk("restart_done_clr", thread_done_out, 0);
    chk("restart_addr0", imem_addr, 0);
    drive(0, 0, 0, 0);
    chk("restart_addr1", imem_addr, 128);

    // Branch on thread 1 while its fetch is in flight.
    do_reset();
    fill_plain();
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 1, 2'd1, 9'h150);
    chk("br_issue_t1", imem_addr, 128);
    drive(0, 0, 0, 0);
    chk("br_squash", inst_valid, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("br_new_addr", imem_addr, 9'h150);
    drive(0, 0, 0, 0);
    chk("br_new_inst", inst_out, nh(9'h150));
    chk("br_new_tid", thread_id_out, 1);

    // Single live thread wraps 511 -> 0 -> 1, then halt beats a same-thread branch.
    do_reset();
    fill_plain();
    mem[1] = HALT; mem[129] = HALT; mem[257] = HALT;
    drive(1, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      drive(0, 0, 0, 0);
      if (thread_done_out == 4'b0111) break;
    end
    chk("wrap_three_done", thread_done_out, 4'b0111);
    drive(0, 1, 2'd3, 9'd511);
    drive(0, 0, 0, 0);
    chk("wrap_addr511", imem_addr, 511);
    drive(0, 0, 0, 0);
    chk("wrap_addr0", imem_addr, 0);
    chk("wrap_ret511_tid", thread_id_out, 3);
    chk("wrap_ret511_inst", inst_out, nh(511));
    drive(0, 0, 0, 0);
    chk("wrap_addr1", imem_addr, 1);
    chk("wrap_ret0_tid", thread_id_out, 3);
    drive(0, 1, 2'd3, 9'h020);
    chk("wrap_halt_ret", inst_out, HALT);
    chk("wrap_halt_valid", inst_valid, 1);
    drive(0, 0, 0, 0);
    chk("halt_beats_br", thread_done_out, 4'hF);
    drive(0, 0, 0, 0);
    chk("wrap_all_done", all_done, 1);

    // Asynchronous reset mid-run.
    do_reset();
    fill_plain();
    drive(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0);
      chk("post_rst_no_valid", inst_valid, 0);
      chk("post_rst_idle", busy, 0);
    end

    // Randomized runs: random memory with sparse halts, random redirects and starts.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int a = 0; a < (1 << AW); a++) begin
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 29) == 0) w[31:26] = 6'h3F;
        else if (w[31:26] == 6'h3F) w[31:26] = 6'h00;
        mem[a] = w;
      end
      drive(1, 0, 0, 0);
      for (int i = 0; i < 600; i++) begin
        drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
              TB'($urandom_range(0, NT - 1)), AW'($urandom_range(0, (1 << AW) - 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/thread_fetch_sched.md
Name: thread_fetch_sched

Overview:
- Fine-grained multithreaded fetch front end. Feeds `inst_decoder` with `inst_in` and `thread_id` each cycle.
- Holds one PC per hardware thread and issues round-robin over threads not yet halted.
- Retires a thread when its halt opcode (6'b111111) returns from instruction memory.
- Accepts branch redirects from the execute stage. Raises `all_done` when every thread has halted.

Parameters:
- INST_WIDTH, 32, instruction word width
- INST_ADDR_WIDTH, 9, instruction memory address width
- THREAD_BITS, 2, thread id width
- NUM_THREADS, 4, hardware threads, 2**THREAD_BITS

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begin a run from IDLE or DONE
- imem_addr  out  INST_ADDR_WIDTH  instruction memory read address (synchronous RAM, 1-cycle read latency)
- imem_rdata  in  INST_WIDTH  instruction memory read data for the previous cycle's address
- inst_out  out  INST_WIDTH  instruction to decoder
- thread_id_out  out  THREAD_BITS  owning thread of inst_out
- inst_valid  out  1  inst_out is live; when 0, inst_out is forced to 0
- br_taken  in  1  redirect request
- br_thread  in  THREAD_BITS  thread being redirected
- br_target  in  INST_ADDR_WIDTH  absolute redirect address
- thread_done_out  out  NUM_THREADS  sticky per-thread halted flags
- busy  out  1  FSM in RUN
- all_done  out  1  FSM in DONE

Behaviour:
- Reset (async, reset_n=0) forces:
  - FSM to IDLE, all outputs 0
  - pc[t] = t << (INST_ADDR_WIDTH-THREAD_BITS), i.e. base 0/128/256/384 at defaults
  - rr pointer = NUM_THREADS-1; fetch-stage valid cleared
  - Reset mid-run discards any in-flight fetch.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE in the cycle after the last thread_done bit sets.
  - DONE -> RUN on start.
  - start in RUN is ignored.
  - Entering RUN from DONE reloads base PCs and clears thread_done_out and rr pointer exactly as reset does.
- Issue stage (RUN only):
  - Select the first thread t after the rr pointer, cyclically, with thread_done[t]=0.
  - Drive imem_addr=pc[t]; pc[t] <= pc[t]+1, wrapping modulo 2**INST_ADDR_WIDTH; rr <= t.
  - Register f_valid=1 and f_tid=t.
  - If no eligible thread, f_valid=0 and imem_addr holds its last value.
- Return stage, one cycle after issue:
  - inst_out=imem_rdata and thread_id_out=f_tid, presented combinationally from the registered fetch info.
  - inst_valid = f_valid & ~squash.
  - Issue-to-inst_out latency is 1 cycle.
- Halt:
  - If inst_valid and inst_out[31:26]==6'b111111, thread_done[f_tid] <= 1 at the next edge.
  - The halt word itself is presented with inst_valid=1 so the decoder sees it.
  - The thread is ineligible for issue in the same cycle the halt is returned.
  - Any same-thread fetch issued that cycle is squashed next cycle.
- Branch (br_taken=1, RUN only):
  - pc[br_thread] <= br_target. This has priority over the increment when br_thread is also issuing this cycle.
  - If f_tid==br_thread this cycle, that fetch is squashed (inst_valid=0 next output).
  - br_taken for a thread already done is ignored.
- squash = thread_done[f_tid] | squash_flag set by branch/halt rules above.
- Boundary cases:
  - Single live thread issues every cycle.
  - PC wraps silently.
  - Simultaneous halt return and branch on the same thread: halt wins, and the thread is done.

Optional Feature:
- Macro: CYCLE_COUNT_EN
- When defined, adds output run_cycles [31:0]:
  - cleared on reset and on entering RUN
  - increments every cycle in RUN
  - holds in DONE
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Memory preloaded with sequential non-halt words, start pulse.
  - inst_valid rises 1 cycle after RUN.
  - thread_id_out cycles 0,1,2,3,0.
  - imem_addr cycles 0,128,256,384,1.
- Thread 2 has halt word at addr 258.
  - thread_done_out=4'b0100 after it returns.
  - Issue order thereafter is 0,1,3 only.
- All threads halt at their base+2.
  - all_done=1, busy=0 one cycle after the 4th done bit.
  - Start pulse: PCs reload to bases, thread_done_out=0.
- br_taken=1, br_thread=1, br_target=9'h150 in a cycle where thread 1's fetch is in flight.
  - That fetch returns with inst_valid=0.
  - Thread 1's next imem_addr is 0x150.
- Threads 0-2 halted; thread 3 at pc=511.
  - Consecutive imem_addr 511, 0, 1, all with thread_id_out=3.
- reset_n pulsed low mid-run.
  - All outputs 0 immediately (asynchronously).
  - IDLE after release; no inst_valid until start.
  - With CYCLE_COUNT_EN: run_cycles=0.
